master_out_port: RTL
====================

Name: master_out_port

Overview:
- Serial-bus master transmit port: the initiator end of the bus that the slave input port receives from.
- Accepts a parallel request (12-bit address, 8-bit write data, read/write type, burst control) from the master core.
- Performs the m_valid/s_ready handshake, then serializes address and data LSB-first on tx_address/tx_data.
- For write bursts, sends further 8-bit data beats; the slave auto-increments the address for each beat.

Parameters:
ADDR_W, 12, address width / address shift length in cycles
DATA_W, 8, data width / data shift length in cycles
BURST_W, 12, burst length field width

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk)
req_valid  input  1  core request valid
req_ready  output  1  port can accept a request (high only in IDLE)
req_addr  input  12  start address
req_wdata  input  8  first-beat write data
req_write  input  1  write request
req_read  input  1  read request
req_burst_en  input  1  burst enable
req_burst_len  input  12  additional beats after the first
beat_wdata  input  8  data for burst beats 2..N
beat_valid  input  1  beat data valid
beat_ready  output  1  port takes beat_wdata this cycle
s_ready  input  1  slave ready
m_valid  output  1  master valid
tx_address  output  1  serial address line
tx_data  output  1  serial data line
write_enable  output  1  write type to slave
read_enable  output  1  read type to slave
burst  output  13  {burst_len, burst_en} to slave
busy  output  1  transaction in progress
done  output  1  one-cycle pulse when the transaction completes
beat_count  output  12  beats fully sent in the current transaction

Behaviour:
- Reset (reset=0 at a clk edge): state IDLE. m_valid, tx_address, tx_data, write_enable, read_enable, beat_ready, busy and done = 0; burst = 0; beat_count = 0. This applies mid-transaction too; shifting is abandoned and no done pulse is generated.
- All outputs are registered except req_ready (= state==IDLE) and beat_ready (= state==BURST_LOAD).
- Type decode:
  - req_write=1 → write; write_enable=1, read_enable=0. Write has priority if req_read is also 1.
  - req_write=0 → address-only transfer; read_enable=req_read, tx_data held 0.
- Total beats = req_burst_en ? req_burst_len+1 : 1. Burst beats apply to writes only. A read burst sends its address once and the slave handles the rest.
- IDLE: on req_valid=1 → latch the request, load the address shift register (ADDR_W) and data shift register (DATA_W, or 0 for a read). Drive tx_address=addr[0], tx_data=wdata[0] (0 for a read), drive enables and burst, set busy=1 and m_valid=1, go to WAIT_HS. Latency from request accept to m_valid is 1 cycle.
- WAIT_HS: hold all outputs until a cycle where m_valid && s_ready (call it cycle H). At cycle H, bit 0 is on the lines.
  - At the edge ending H: m_valid←0, go to ADDR_SHIFT with the bit counter at 1.
- ADDR_SHIFT: one address bit per cycle. Bit i appears on tx_address in cycle H+i, for i=0..11.
  - Data bit j appears on tx_data in cycle H+j, for j=0..7; tx_data=0 from H+8 through H+11.
  - s_ready changes during shifting are ignored.
  - After cycle H+11: if write and beats remain → BURST_LOAD; else → FINISH.
- BURST_LOAD: beat_ready=1. On beat_valid=1 → load beat_wdata, put tx_data=bit0, set m_valid=1, go to BURST_HS. tx_address is held 0 during bursts.
- BURST_HS: wait for m_valid && s_ready (cycle B). Data bit j appears in cycle B+j; m_valid←0 after B; go to BURST_SHIFT.
- BURST_SHIFT: after cycle B+7, beat_count increments. If beats remain → BURST_LOAD; else → FINISH.
- beat_count increments at the end of each completed beat, including the first (end of H+11). It saturates at 4095.
- FINISH: done=1 for exactly one cycle. Enables, busy and lines cleared to 0, burst=0, return to IDLE. req_ready is high the following cycle; a new request is at earliest 1 cycle after done.
- req_burst_len=0 with req_burst_en=1: single beat, with burst output still {0,1}.
- Request fields are sampled only at accept; later input changes are ignored.

Test Plan:
- Single write, addr=0xA5C, data=0x3B, s_ready already 1 → m_valid 1 cycle after accept. tx_address shows 0,0,1,1,1,0,1,0,0,1,0,1 over H..H+11; tx_data shows 1,1,0,1,1,1,0,0 then 0s; done pulses at H+12; write_enable=1 throughout.
- Read, addr=0x001, s_ready held 0 for 5 cycles → m_valid stays 1 and outputs stable; after handshake, tx_data=0 always, read_enable=1, beat_count=1 at done.
- Write burst, burst_len=2, beat data 0x11 then 0x22 with beat_valid delayed 3 cycles → burst=0x005; beats are sent after each handshake; beat_count=3; a single done.
- req_read=1 and req_write=1 → treated as write: read_enable=0, write_enable=1.
- Reset driven to 0 at H+5 → next edge: all outputs 0, IDLE, req_ready=1, no done pulse.
- s_ready toggled during ADDR_SHIFT → serial bit stream unchanged; m_valid remains 0 until the next beat.

Source files
------------

// File: rtl/master_out_port.sv
// Serial-bus master transmit port: accepts a parallel request, handshakes with the slave,
// then shifts address and data LSB-first, with optional write-burst data beats.
module master_out_port #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned BURST_W = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [DATA_W-1:0]  req_wdata,
    input  logic               req_write,
    input  logic               req_read,
    input  logic               req_burst_en,
    input  logic [BURST_W-1:0] req_burst_len,
    input  logic [DATA_W-1:0]  beat_wdata,
    input  logic               beat_valid,
    output logic               beat_ready,
    input  logic               s_ready,
    output logic               m_valid,
    output logic               tx_address,
    output logic               tx_data,
    output logic               write_enable,
    output logic               read_enable,
    output logic [BURST_W:0]   burst,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] beat_count
);

    localparam int unsigned CntW = $clog2(ADDR_W);
    localparam logic [CntW-1:0] AddrLast = CntW'(ADDR_W - 1);
    localparam logic [CntW-1:0] DataLast = CntW'(DATA_W - 1);

    typedef enum logic [2:0] {
        StIdle, StWaitHs, StAddrShift, StBurstLoad, StBurstHs, StBurstShift, StFinish
    } state_e;

    state_e state_q, state_d;
    logic [ADDR_W-1:0]  addr_sr_q, addr_sr_d;
    logic [DATA_W-1:0]  data_sr_q, data_sr_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [BURST_W-1:0] rem_q, rem_d;
    logic [BURST_W-1:0] beat_count_q, beat_count_d;
    logic [BURST_W:0]   burst_q, burst_d;
    logic               write_q, write_d;
    logic               read_q, read_d;
    logic               m_valid_q, m_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Serial lines are the LSBs of the shift registers; zero fill keeps lines low afterwards.
    assign tx_address   = addr_sr_q[0];
    assign tx_data      = data_sr_q[0];
    assign req_ready    = (state_q == StIdle);
    assign beat_ready   = (state_q == StBurstLoad);
    assign m_valid      = m_valid_q;
    assign write_enable = write_q;
    assign read_enable  = read_q;
    assign burst        = burst_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign beat_count   = beat_count_q;

    always_comb begin
        state_d      = state_q;
        addr_sr_d    = addr_sr_q;
        data_sr_d    = data_sr_q;
        cnt_d        = cnt_q;
        rem_d        = rem_q;
        beat_count_d = beat_count_q;
        burst_d      = burst_q;
        write_d      = write_q;
        read_d       = read_q;
        m_valid_d    = m_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_sr_d    = req_addr;
                    data_sr_d    = req_write ? req_wdata : '0;
                    write_d      = req_write;
                    read_d       = ~req_write & req_read;
                    burst_d      = {req_burst_len, req_burst_en};
                    // Extra beats only exist for writes; a read burst is a single address.
                    rem_d        = (req_write && req_burst_en) ? req_burst_len : '0;
                    beat_count_d = '0;
                    cnt_d        = '0;
                    m_valid_d    = 1'b1;
                    busy_d       = 1'b1;
                    state_d      = StWaitHs;
                end
            end
            StWaitHs: begin
                if (m_valid_q && s_ready) begin
                    m_valid_d = 1'b0;
                    addr_sr_d = addr_sr_q >> 1;
                    data_sr_d = data_sr_q >> 1;
                    cnt_d     = CntW'(1);
                    state_d   = StAddrShift;
                end
            end
            StAddrShift: begin
                addr_sr_d = addr_sr_q >> 1;
                data_sr_d = data_sr_q >> 1;
                cnt_d     = cnt_q + CntW'(1);
                if (cnt_q == AddrLast) begin
                    addr_sr_d = '0;
                    data_sr_d = '0;
                    if (beat_count_q != '1) beat_count_d = beat_count_q + BURST_W'(1);
                    if (write_q && rem_q != '0) begin
                        state_d = StBurstLoad;
                    end else begin
                        done_d  = 1'b1;
                        state_d = StFinish;
                    end
                end
            end
            StBurstLoad: begin
                if (beat_valid) begin
                    data_sr_d = beat_wdata;
                    m_valid_d = 1'b1;
                    state_d   = StBurstHs;
                end
            end
            StBurstHs: begin
                if (m_valid_q && s_ready) begin
                    m_valid_d = 1'b0;
                    data_sr_d = data_sr_q >> 1;
                    cnt_d     = CntW'(1);
                    state_d   = StBurstShift;
                end
            end
            StBurstShift: begin
                data_sr_d = data_sr_q >> 1;
                cnt_d     = cnt_q + CntW'(1);
                if (cnt_q == DataLast) begin
                    data_sr_d = '0;
                    rem_d     = rem_q - BURST_W'(1);
                    if (beat_count_q != '1) beat_count_d = beat_count_q + BURST_W'(1);
                    if (rem_d != '0) begin
                        state_d = StBurstLoad;
                    end else begin
                        done_d  = 1'b1;
                        state_d = StFinish;
                    end
                end
            end
            StFinish: begin
                write_d   = 1'b0;
                read_d    = 1'b0;
                burst_d   = '0;
                busy_d    = 1'b0;
                m_valid_d = 1'b0;
                addr_sr_d = '0;
                data_sr_d = '0;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            addr_sr_q    <= '0;
            data_sr_q    <= '0;
            cnt_q        <= '0;
            rem_q        <= '0;
            beat_count_q <= '0;
            burst_q      <= '0;
            write_q      <= 1'b0;
            read_q       <= 1'b0;
            m_valid_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_sr_q    <= addr_sr_d;
            data_sr_q    <= data_sr_d;
            cnt_q        <= cnt_d;
            rem_q        <= rem_d;
            beat_count_q <= beat_count_d;
            burst_q      <= burst_d;
            write_q      <= write_d;
            read_q       <= read_d;
            m_valid_q    <= m_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

endmodule
